stopwatch_ctrl: RTL

Run/pause/clear controller for the 4-digit BCD time-base counter. It gates a prescaler that produces a one-cycle tick and sequences a cascaded BCD digit chain with per-digit carry enables. It sits between the debounced front-panel buttons and the display scanner, which consumes cnt.

---
 rtl/stopwatch_pkg.sv | 13 +
 rtl/stopwatch_ctrl_bcd_digit.sv | 24 ++
 rtl/stopwatch_ctrl.sv | 108 ++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch time-base controller.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam logic [3:0]  BCD_MAX    = 4'd9;
    localparam int unsigned NUM_DIGITS = 4;

endpackage

// File: rtl/stopwatch_ctrl_bcd_digit.sv
// Single BCD digit: counts 0..9 on inc, wraps 9 -> 0, clears on clr.
module bcd_digit
    import stopwatch_pkg::*;
(
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] q,
    output logic       is9
);

    assign is9 = (q == BCD_MAX);

    // Digit register; clear wins over increment.
    always_ff @(posedge sys_clk) begin
        if (sys_rst || clr) begin
            q <= '0;
        end else if (inc) begin
            q <= is9 ? '0 : q + 4'd1;
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/pause/clear controller: button edge detect, FSM, gated prescaler
// and a cascaded 4-digit BCD counter with per-digit carry enables.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50_000_000,
    parameter bit          WRAP     = 1'b1
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        start_stop,
    input  logic        clear,
    output logic        tick,
    output logic [2:0]  en,
    output logic [15:0] cnt,
    output logic        running,
    output logic        ovf
);

    localparam int unsigned     DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    state_t                  state;
    logic [DIV_W-1:0]        div;
    logic                    ss_q;
    logic                    clr_q;
    logic                    ss_rise;
    logic                    clr_rise;
    logic [NUM_DIGITS:0]     carry;
    logic [NUM_DIGITS-1:0]   inc;
    logic [NUM_DIGITS-1:0]   is9;
    logic                    full;
    logic                    sat;

    assign ss_rise  = start_stop & ~ss_q;
    assign clr_rise = clear & ~clr_q;
    assign running  = (state == RUN);
    assign tick     = (state == RUN) && (div == DIV_LAST);

    // Ripple carry: carry[k] is the increment request into digit k.
    always_comb begin
        carry    = '0;
        carry[0] = tick;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            carry[k+1] = carry[k] & is9[k];
        end
    end

    assign en   = carry[NUM_DIGITS-1:1];
    assign full = carry[NUM_DIGITS];
    // In saturate mode a tick at 9999 must leave every digit untouched.
    assign sat  = full & ~WRAP;
    assign inc  = carry[NUM_DIGITS-1:0] & {NUM_DIGITS{~sat}};

    // Button history for rising-edge detection.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            ss_q  <= 1'b0;
            clr_q <= 1'b0;
        end else begin
            ss_q  <= start_stop;
            clr_q <= clear;
        end
    end

    // Control FSM and sticky overflow flag.
    always_ff @(posedge sys_clk) begin
        if (sys_rst || clr_rise) begin
            state <= IDLE;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ss_rise) state <= RUN;
                end
                RUN: begin
                    if (full) ovf <= 1'b1;
                    if (ss_rise || sat) state <= PAUSE;
                end
                PAUSE: begin
                    if (ss_rise) state <= RUN;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Prescaler: counts in RUN, frozen in PAUSE, zero in IDLE.
    always_ff @(posedge sys_clk) begin
        if (sys_rst || clr_rise || state == IDLE) begin
            div <= '0;
        end else if (state == RUN) begin
            div <= (div == DIV_LAST) ? '0 : div + DIV_W'(1);
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .sys_clk (sys_clk),
            .sys_rst (sys_rst),
            .clr     (clr_rise),
            .inc     (inc[g]),
            .q       (cnt[4*g +: 4]),
            .is9     (is9[g])
        );
    end

endmodule
